// File: rtl/rns_relu_pkg.sv
// Shared constants for the RNS ReLU block: moduli set {2^N+1, 2^N, 2^N-1}.
package rns_relu_pkg;

  localparam int unsigned RNS_N  = 5;
  localparam int unsigned MOD1   = 33;
  localparam int unsigned MOD2   = 32;
  localparam int unsigned MOD3   = 31;
  localparam int unsigned M      = MOD1 * MOD2 * MOD3;
  localparam int unsigned NEG_TH = 16368;
  localparam int unsigned X_W    = 15;
  // Inverse of MOD1*MOD2 (=1056 = 2 mod 31) modulo MOD3.
  localparam int unsigned INV_12_3 = 16;

endpackage

// File: rtl/rns_relu_sign_3set.sv
// Sign detector for a canonical residue triple: mixed-radix conversion, then
// compare the reconstructed value against the negative threshold.
module sign_3set
  import rns_relu_pkg::*;
(
  input  logic [RNS_N:0]   in1,
  input  logic [RNS_N-1:0] in2,
  input  logic [RNS_N-1:0] in3,
  output logic             sign
);

  logic [RNS_N-1:0] w_v2;
  logic [7:0]       w_tmp;
  logic [11:0]      w_prod;
  logic [RNS_N-1:0] w_v3;
  logic [X_W-1:0]   w_x;

  // MOD1 = 1 mod 32, so the second digit is a plain 5-bit difference.
  assign w_v2   = in2 - in1[RNS_N-1:0];
  // 4*MOD3 bias keeps the third-digit numerator non-negative.
  assign w_tmp  = 8'(in3) + 8'(4 * MOD3) - 8'(in1) - 8'({w_v2, 1'b0});
  assign w_prod = 12'(w_tmp) * 12'(INV_12_3);
  assign w_v3   = RNS_N'(w_prod % 12'(MOD3));
  assign w_x    = X_W'(in1) + X_W'(w_v2) * X_W'(MOD1) + X_W'(w_v3) * X_W'(MOD1 * MOD2);
  assign sign   = (w_x >= X_W'(NEG_TH));

endmodule

// File: rtl/rns_relu.sv
// Two-stage ReLU on RNS triples with a per-frame count of negative values.
module rns_relu
  import rns_relu_pkg::*;
#(
  parameter int unsigned N  = 5,
  parameter int unsigned CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [N:0]    s_r1,
  input  logic [N-1:0]  s_r2,
  input  logic [N-1:0]  s_r3,
  input  logic          s_last,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [N:0]    m_r1,
  output logic [N-1:0]  m_r2,
  output logic [N-1:0]  m_r3,
  output logic          m_last,
  output logic [CW-1:0] neg_count,
  output logic          cnt_valid
);

  logic          r_s0_valid, r_s0_last;
  logic [N:0]    r_s0_r1;
  logic [N-1:0]  r_s0_r2, r_s0_r3;
  logic          r_s1_valid, r_s1_last, r_s1_sign;
  logic [N:0]    r_s1_r1;
  logic [N-1:0]  r_s1_r2, r_s1_r3;
  logic [CW-1:0] r_cnt, r_neg_count;
  logic          r_cnt_valid;
  logic          w_adv, w_sign, w_xfer_out;
  logic [CW-1:0] w_cnt_inc;

  assign w_adv      = ~r_s1_valid | m_ready;
  assign s_ready    = w_adv | ~r_s0_valid;
  assign w_xfer_out = r_s1_valid & m_ready;

  sign_3set u_sign (
    .in1  (r_s0_r1),
    .in2  (r_s0_r2),
    .in3  (r_s0_r3),
    .sign (w_sign)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s0_valid <= 1'b0;
      r_s0_last  <= 1'b0;
      r_s0_r1    <= '0;
      r_s0_r2    <= '0;
      r_s0_r3    <= '0;
    end else if (s_ready) begin
      r_s0_valid <= s_valid;
      if (s_valid) begin
        r_s0_r1   <= s_r1;
        r_s0_r2   <= s_r2;
        r_s0_r3   <= s_r3;
        r_s0_last <= s_last;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_sign  <= 1'b0;
      r_s1_r1    <= '0;
      r_s1_r2    <= '0;
      r_s1_r3    <= '0;
    end else if (w_adv) begin
      r_s1_valid <= r_s0_valid;
      if (r_s0_valid) begin
        r_s1_r1   <= r_s0_r1;
        r_s1_r2   <= r_s0_r2;
        r_s1_r3   <= r_s0_r3;
        r_s1_last <= r_s0_last;
        r_s1_sign <= w_sign;
      end
    end
  end

  // Saturating increment; frame total includes the triple carrying last.
  assign w_cnt_inc = (r_s1_sign && (r_cnt != '1)) ? r_cnt + CW'(1) : r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_neg_count <= '0;
      r_cnt_valid <= 1'b0;
    end else begin
      r_cnt_valid <= 1'b0;
      if (w_xfer_out) begin
        if (r_s1_last) begin
          r_neg_count <= w_cnt_inc;
          r_cnt_valid <= 1'b1;
          r_cnt       <= '0;
        end else begin
          r_cnt <= w_cnt_inc;
        end
      end
    end
  end

  assign m_valid   = r_s1_valid;
  assign m_r1      = r_s1_sign ? '0 : r_s1_r1;
  assign m_r2      = r_s1_sign ? '0 : r_s1_r2;
  assign m_r3      = r_s1_sign ? '0 : r_s1_r3;
  assign m_last    = r_s1_last;
  assign neg_count = r_neg_count;
  assign cnt_valid = r_cnt_valid;

endmodule
